// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizes and Gray-code helper for the FIFO read side
package fifo_pkg;
  localparam int DEF_DATA_WIDTH = 41;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int OUT_BUF_DEPTH = 2;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/fifo_out_buf.sv
// fifo_out_buf: 2-entry output buffer whose head comes straight from a flop
module fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head
);
  logic [1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
  logic pop_ok;
  assign pop_ok = pop && count_q != 2'd0;
  // Head holds its last value when emptied; a push into an empty buffer lands in the head slot.
  always_comb begin
    count_d = count_q + 2'(push) - 2'(pop_ok);
    e0_d = pop_ok ? (count_q == 2'd2 ? e1_q : push ? push_data : e0_q)
                  : (push && count_q == 2'd0 ? push_data : e0_q);
    e1_d = push && (count_q - 2'(pop_ok)) == 2'd1 ? push_data : e1_q;
  end
  // Buffer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      e0_q <= '0;
      e1_q <= '0;
    end else begin
      count_q <= count_d;
      e0_q <= e0_d;
      e1_q <= e1_d;
    end
  end
  assign count = count_q;
  assign head = e0_q;
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: async FIFO read-side controller presenting a valid/ready stream
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic [ADDR_WIDTH:0]   wq2_wptr,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  fifo_empty,
  output logic                  drained
);
  localparam int PW = ADDR_WIDTH + 1;
  logic [PW-1:0] rbin_q, rbin_d, rgray_q, rgray_d;
  logic inflight_q, inflight_d;
  logic [1:0] count;
  logic pop;
  assign fifo_empty = rgray_q == wq2_wptr;
  assign pop = m_valid && m_ready;
  assign m_valid = count != 2'd0;
  assign mem_rd_addr = rbin_q[ADDR_WIDTH-1:0];
  assign rd_ptr_gray = rgray_q;
  assign drained = fifo_empty && !inflight_q && count == 2'd0;
  // Issue a read only while buffered plus in-flight words after this cycle's pop leave room.
  always_comb begin
    mem_rd_en = !rd_rst && !fifo_empty
                && ({1'b0, count} + {2'b0, inflight_q} - {2'b0, pop}) < 3'(OUT_BUF_DEPTH);
    rbin_d = rbin_q + PW'(mem_rd_en);
    rgray_d = PW'(bin2gray(32'(rbin_d)));
    inflight_d = mem_rd_en;
  end
  // Pointer and in-flight registers; the Gray pointer leaves the block straight from a flop.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      rbin_q <= '0;
      rgray_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      rbin_q <= rbin_d;
      rgray_q <= rgray_d;
      inflight_q <= inflight_d;
    end
  end
  fifo_out_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk(rd_clk),
    .rst(rd_rst),
    .push(inflight_q),
    .push_data(mem_rd_data),
    .pop(pop),
    .count(count),
    .head(m_data)
  );
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: scoreboard bench for the FIFO read-side stream controller
module tb_fifo_rd_stream;
  logic rd_clk = 1'b0;
  logic rd_rst = 1'b1;
  logic [4:0] wq2_wptr = '0;
  logic [4:0] rd_ptr_gray;
  logic mem_rd_en;
  logic [3:0] mem_rd_addr;
  logic [40:0] mem_rd_data = '0;
  logic m_valid;
  logic m_ready = 1'b0;
  logic [40:0] m_data;
  logic fifo_empty;
  logic drained;
  logic [40:0] mem [16];
  logic [40:0] exp_q [$];
  logic [4:0] wbin = '0;
  int total = 0;
  int bad = 0;
  int n;
  int wa [4] = '{14, 15, 0, 1};
  logic [4:0] gs [4] = '{5'b10001, 5'b10000, 5'b00000, 5'b00001};
  logic [4:0] pat = 5'b01101;

  fifo_rd_stream dut (
    .rd_clk(rd_clk),
    .rd_rst(rd_rst),
    .wq2_wptr(wq2_wptr),
    .rd_ptr_gray(rd_ptr_gray),
    .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .fifo_empty(fifo_empty),
    .drained(drained)
  );

  always #5 rd_clk = ~rd_clk;

  always @(posedge rd_clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  always @(negedge rd_clk) begin
    if (!rd_rst && m_valid && m_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL stream: got %h want nothing (unexpected word)", m_data);
      end else if (m_data !== exp_q[0]) begin
        bad++;
        $display("FAIL stream: got %h want %h", m_data, exp_q[0]);
        void'(exp_q.pop_front());
      end else begin
        void'(exp_q.pop_front());
      end
    end
  end

  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic put(input logic [40:0] d);
    mem[wbin[3:0]] = d;
    exp_q.push_back(d);
    wbin = wbin + 5'd1;
  endtask

  initial begin
    repeat (3) tick();
    rd_rst = 1'b0;
    #1;
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_data", 64'(m_data), 64'd0);
    chk("rst_en", 64'(mem_rd_en), 64'd0);
    chk("rst_gray", 64'(rd_ptr_gray), 64'd0);
    chk("rst_empty", 64'(fifo_empty), 64'd1);
    chk("rst_drained", 64'(drained), 64'd1);
    tick();
    m_ready = 1'b1;
    put(41'h1_0000_00AB);
    wq2_wptr = g(wbin);
    #1;
    chk("single_en_c0", 64'(mem_rd_en), 64'd1);
    chk("single_addr_c0", 64'(mem_rd_addr), 64'd0);
    tick();
    chk("single_en_c1", 64'(mem_rd_en), 64'd0);
    chk("single_valid_c1", 64'(m_valid), 64'd0);
    tick();
    chk("single_valid_c2", 64'(m_valid), 64'd1);
    chk("single_data_c2", 64'(m_data), 64'h1_0000_00AB);
    tick();
    chk("single_gray", 64'(rd_ptr_gray), 64'd1);
    chk("single_drained", 64'(drained), 64'd1);
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) put(41'h0_F000_0000 + 41'(k));
    wq2_wptr = g(wbin);
    repeat (4) tick();
    chk("pre_rst_valid", 64'(m_valid), 64'd1);
    chk("pre_rst_en", 64'(mem_rd_en), 64'd0);
    rd_rst = 1'b1;
    wq2_wptr = '0;
    wbin = '0;
    exp_q.delete();
    repeat (3) tick();
    rd_rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_en", 64'(mem_rd_en), 64'd0);
    chk("mid_rst_gray", 64'(rd_ptr_gray), 64'd0);
    chk("mid_rst_drained", 64'(drained), 64'd1);
    m_ready = 1'b1;
    for (int k = 0; k < 16; k++) put(41'h0_A000_0000 + 41'(k));
    wq2_wptr = g(wbin);
    #1;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        chk("stream_en", 64'(mem_rd_en), 64'd1);
        chk("stream_addr", 64'(mem_rd_addr), 64'(i));
      end
      if (i >= 2) chk("stream_valid", 64'(m_valid), 64'd1);
      tick();
    end
    chk("stream_en_end", 64'(mem_rd_en), 64'd0);
    chk("stream_gray", 64'(rd_ptr_gray), 64'b11000);
    chk("stream_empty", 64'(fifo_empty), 64'd1);
    chk("stream_left", 64'(exp_q.size()), 64'd0);
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) put(41'h0_B000_0000 + 41'(k));
    wq2_wptr = g(wbin);
    #1;
    n = 0;
    repeat (6) begin
      n += int'(mem_rd_en);
      tick();
    end
    chk("bp_issues", 64'(n), 64'd2);
    chk("bp_valid", 64'(m_valid), 64'd1);
    chk("bp_hold", 64'(m_data), 64'h0_B000_0000);
    m_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_nogap", 64'(m_valid), 64'd1);
      tick();
    end
    repeat (2) tick();
    chk("bp_left", 64'(exp_q.size()), 64'd0);
    for (int k = 0; k < 8; k++) put(41'h0_C000_0000 + 41'(k));
    wq2_wptr = g(wbin);
    for (int i = 0; i < 20; i++) begin
      m_ready = pat[i % 5];
      tick();
    end
    m_ready = 1'b1;
    repeat (4) tick();
    chk("tog_left", 64'(exp_q.size()), 64'd0);
    put(41'h0_D000_0000);
    wq2_wptr = g(wbin);
    repeat (4) tick();
    chk("fill_left", 64'(exp_q.size()), 64'd0);
    chk("wrap_gray_start", 64'(rd_ptr_gray), 64'b10001);
    for (int k = 0; k < 4; k++) put(41'h0_E000_0000 + 41'(k));
    wq2_wptr = g(wbin);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_en", 64'(mem_rd_en), 64'd1);
      chk("wrap_addr", 64'(mem_rd_addr), 64'(wa[i]));
      chk("wrap_gray", 64'(rd_ptr_gray), 64'(gs[i]));
      tick();
    end
    chk("wrap_en_end", 64'(mem_rd_en), 64'd0);
    chk("wrap_gray_end", 64'(rd_ptr_gray), 64'b00011);
    repeat (3) tick();
    chk("wrap_left", 64'(exp_q.size()), 64'd0);
    chk("final_drained", 64'(drained), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side controller for the bridge's async FIFO, clocked entirely in the read (SPI) domain. It owns the read pointer and detects empty against the write pointer, which arrives already synchronized and Gray-coded. It drives the memory read port and absorbs the memory's 1-cycle registered read latency. Data is presented to the SPI-side consumer as a valid/ready stream at full throughput.

Parameters:
DATA_WIDTH, 41, width of one FIFO word (control + address + data)
ADDR_WIDTH, 4, memory address width; FIFO depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits

Ports:
rd_clk  in  1  read-domain clock
rd_rst  in  1  synchronous reset, active-high
wq2_wptr  in  ADDR_WIDTH+1  write pointer, Gray, already 2-flop synchronized into rd_clk
rd_ptr_gray  out  ADDR_WIDTH+1  registered Gray read pointer, to the write-domain synchronizer
mem_rd_en  out  1  memory read enable
mem_rd_addr  out  ADDR_WIDTH  memory read address (low bits of binary read pointer)
mem_rd_data  in  DATA_WIDTH  memory read data, valid the cycle after mem_rd_en
m_valid  out  1  output word valid
m_ready  in  1  consumer accepts word
m_data  out  DATA_WIDTH  output word
fifo_empty  out  1  memory holds no unread word: Gray read pointer == wq2_wptr
drained  out  1  fifo_empty && nothing in flight && output buffer empty

Behaviour:
- Reset, sampled on rd_clk:
  - Binary and Gray read pointers = 0; in-flight flag = 0; output buffer count = 0.
  - m_valid = 0, m_data = 0, mem_rd_en = 0, rd_ptr_gray = 0.
  - fifo_empty and drained reflect the reset pointers.
- Pointers:
  - rbin is ADDR_WIDTH+1 bits and wraps 2^(ADDR_WIDTH+1)-1 -> 0.
  - rgray = rbin ^ (rbin >> 1), registered; rd_ptr_gray comes straight from a flop, never from logic.
- Issue rule (combinational, in the same cycle):
  - pop = m_valid && m_ready.
  - mem_rd_en = !rd_rst && !fifo_empty && (count + inflight - pop) < 2.
  - mem_rd_addr = rbin[ADDR_WIDTH-1:0].
  - On issue: rbin increments, and inflight <= 1 for the next cycle.
- Capture:
  - In the cycle after an issue, mem_rd_data is written into the 2-entry output buffer (fifo_out_buf).
  - Capture and pop in the same cycle is legal; count is unchanged.
- Output:
  - m_valid = (count != 0); m_data = head entry. Both are registered.
  - m_data holds stable while m_valid && !m_ready.
  - m_data is don't-care when m_valid = 0 and is implemented as holding its last value.
- Latency: wq2_wptr showing non-empty in cycle N -> mem_rd_en in cycle N -> m_valid in cycle N+2.
- Throughput: with m_ready held high, 1 word per cycle sustained.
- Backpressure: at most 2 words are read beyond the consumer (buffer + in flight); no word is lost or duplicated.
- Order: words emerge in strict address order, including across the pointer wrap.
- Empty boundary:
  - FIFO empties exactly as a read issues: no further mem_rd_en until wq2_wptr changes.
  - A stale (lagging) wq2_wptr only delays reads; it never causes a false read.
- Full is owned by the write side; this block never inspects it.
- Reset mid-operation: any in-flight word and buffered words are discarded, and pointers return to 0. The write domain must be reset in the same system reset.

Decomposition:
- Package fifo_pkg holds:
  - default DATA_WIDTH/ADDR_WIDTH localparams;
  - function bin2gray;
  - localparam OUT_BUF_DEPTH = 2.
- Sub-module fifo_out_buf:
  - 2-entry synchronous buffer; ports push/push_data/pop/count/head.
  - Reset count = 0.
  - Simultaneous push+pop allowed, including at count 0 (push only takes effect) and at count 2 (pop first).

Test Plan:
- Reset: assert rd_rst 3 cycles mid-stream with 2 words buffered -> next cycle m_valid=0, mem_rd_en=0, rd_ptr_gray=5'b00000, drained=1 once wq2_wptr=0.
- Single word: wq2_wptr 0->5'b00001, mem_rd_data=41'h1_0000_00AB, m_ready=1:
  - mem_rd_en=1 with addr 0 in cycle 0;
  - m_valid=1, m_data=41'h1_0000_00AB in cycle 2;
  - afterwards rd_ptr_gray=5'b00001, drained=1.
- Streaming: 16 words available (wq2_wptr=gray(16)=5'b11000), m_ready=1 -> mem_rd_en 16 consecutive cycles, addresses 0..15; 16 m_valid beats back-to-back in order; final rd_ptr_gray=5'b11000, fifo_empty=1.
- Backpressure: 5 words available, m_ready=0 -> exactly 2 mem_rd_en pulses, then none; m_data holds word0. Raise m_ready -> words 0..4 delivered in order, no gap after the first.
- Wrap: start rbin=30, 4 words available -> addresses 14,15,0,1; rd_ptr_gray sequence 10001,10000,00000,00001; data in order.
- Toggling m_ready: m_ready pattern 1,0,1,1,0 over 8 available words -> pops only on valid&&ready; no duplicate or dropped word (scoreboard compare).
